// File: rtl/console_char_bridge_pkg.sv
// rtl/console_char_bridge_pkg.sv - register map, status fields and drain states
package console_char_bridge_pkg;

   localparam logic [31:0] CON_DATA_OFS = 32'h0;
   localparam logic [31:0] CON_STAT_OFS = 32'h4;

   localparam int ST_FULL      = 0;
   localparam int ST_EMPTY     = 1;
   localparam int ST_SCROLL    = 2;
   localparam int ST_COUNT_LSB = 3;

   typedef enum logic {
      DRAIN_IDLE  = 1'b0,
      DRAIN_ISSUE = 1'b1
   } drain_state_e;

   // Only address bit 2 separates the two registers.
   function automatic logic is_data_addr(input logic haddr2);
      return (haddr2 == CON_DATA_OFS[2]) && (haddr2 != CON_STAT_OFS[2]);
   endfunction

endpackage

// File: rtl/console_char_bridge_sync_fifo.sv
// rtl/console_char_bridge_sync_fifo.sv - single-clock FIFO with head word visible while non-empty
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int PTR_W = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [PTR_W:0]   count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + (PTR_W+1)'(1);
         end else if (do_pop && !do_push) begin
            count <= count - (PTR_W+1)'(1);
         end
      end
   end

endmodule

// File: rtl/console_char_bridge.sv
// rtl/console_char_bridge.sv - AHB-Lite character buffer feeding the text console one char at a time
module console_char_bridge
   import console_char_bridge_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int PTR_W      = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic        HREADY,
   input  logic [31:0] HWDATA,
   output logic        HREADYOUT,
   output logic [31:0] HRDATA,
   output logic        HRESP,
   input  logic        scroll,
   output logic        font_we,
   output logic [7:0]  font_data
);

   logic           xfer_valid;
   logic           wr_q;
   logic           rd_q;
   logic           sel_data_q;
   logic           data_wr;
   logic           fifo_push;
   logic           fifo_pop;
   logic           fifo_full;
   logic           fifo_empty;
   logic [7:0]     fifo_head;
   logic [PTR_W:0] fifo_count;
   drain_state_e   state_q;
   drain_state_e   state_d;
   logic           unused_ok;

   assign unused_ok  = ^{HADDR[31:3], HADDR[1:0], HSIZE, HTRANS[0], HWDATA[31:8]};
   assign xfer_valid = HSEL & HREADY & HTRANS[1];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_q       <= 1'b0;
         rd_q       <= 1'b0;
         sel_data_q <= 1'b0;
      end else if (HREADY) begin
         wr_q       <= xfer_valid & HWRITE;
         rd_q       <= xfer_valid & ~HWRITE;
         sel_data_q <= is_data_addr(HADDR[2]);
      end
   end

   // A DATA write parks in its data phase until a slot frees up.
   assign data_wr   = wr_q & sel_data_q;
   assign fifo_push = data_wr & ~fifo_full;
   assign HREADYOUT = ~(data_wr & fifo_full);
   assign HRESP     = 1'b0;

   always_comb begin
      HRDATA = '0;
      if (rd_q && !sel_data_q) begin
         HRDATA[ST_FULL]                    = fifo_full;
         HRDATA[ST_EMPTY]                   = fifo_empty;
         HRDATA[ST_SCROLL]                  = scroll;
         HRDATA[ST_COUNT_LSB +: PTR_W + 1]  = fifo_count;
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH),
      .PTR_W (PTR_W)
   ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (fifo_push),
      .push_data (HWDATA[7:0]),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // The ISSUE cycle gives the console one edge to raise scroll before the next decision.
   always_comb begin
      state_d  = state_q;
      fifo_pop = 1'b0;
      case (state_q)
         DRAIN_IDLE: begin
            if (!fifo_empty && !scroll) begin
               fifo_pop = 1'b1;
               state_d  = DRAIN_ISSUE;
            end
         end
         DRAIN_ISSUE: state_d = DRAIN_IDLE;
         default:     state_d = DRAIN_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= DRAIN_IDLE;
         font_we   <= 1'b0;
         font_data <= 8'h00;
      end else begin
         state_q <= state_d;
         font_we <= fifo_pop;
         if (fifo_pop) begin
            font_data <= fifo_head;
         end
      end
   end

endmodule

// File: tb/tb_console_char_bridge.sv
// tb/tb_console_char_bridge.sv - directed and randomized checks of console_char_bridge against a queue model
module tb_console_char_bridge;

   logic        clk = 1'b0;
   logic        resetn;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic        HREADY;
   logic [31:0] HWDATA;
   logic        HREADYOUT;
   logic [31:0] HRDATA;
   logic        HRESP;
   logic        scroll;
   logic        font_we;
   logic [7:0]  font_data;

   always #5 clk = ~clk;
   assign HREADY = HREADYOUT;

   console_char_bridge #(.FIFO_DEPTH(16), .PTR_W(4)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HREADY    (HREADY),
      .HWDATA    (HWDATA),
      .HREADYOUT (HREADYOUT),
      .HRDATA    (HRDATA),
      .HRESP     (HRESP),
      .scroll    (scroll),
      .font_we   (font_we),
      .font_data (font_data)
   );

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   logic       scroll_prev = 1'b0;
   logic       prev_we = 1'b0;
   int         scroll_err = 0;
   int         b2b_err = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] wq[$];
   int         pulse_cyc[$];
   int         stall_cycles;
   int         release_cyc;
   int         last_push_cyc;
   int         fall_cyc;
   logic       wrap_busy;

   always @(posedge clk) begin
      cyc         <= cyc + 1;
      scroll_prev <= scroll;
   end

   // Every character leaving the bridge lands here, stamped with its cycle.
   always @(negedge clk) begin
      if (resetn && font_we) begin
         got_q.push_back(font_data);
         pulse_cyc.push_back(cyc);
         if (prev_we) b2b_err <= b2b_err + 1;
         if (scroll_prev) scroll_err <= scroll_err + 1;
      end
      prev_we <= font_we & resetn;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_status();
      int cnt;
      logic [31:0] s;
      cnt = exp_q.size() - got_q.size();
      s = 32'(cnt) << 3;
      if (scroll) s = s | 32'h4;
      if (cnt == 0) s = s | 32'h2;
      if (cnt == 16) s = s | 32'h1;
      return s;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic ahb_write_seq(input logic [31:0] addr);
      int n;
      logic rdy;
      logic [31:0] r;
      n = wq.size();
      rdy = 1'b0;
      for (int i = 0; i <= n; i++) begin
         if (i < n) begin
            HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
         end else begin
            HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
         end
         if (i > 0) begin
            r = $urandom();
            HWDATA = {r[31:8], wq[i-1]};
         end
         for (int w = 0; w < 3000; w++) begin
            @(negedge clk);
            rdy = HREADYOUT;
            if (!rdy) stall_cycles++;
            else if (w > 0) release_cyc = cyc;
            @(posedge clk);
            #1;
            if (rdy) break;
         end
         if (!rdy) check("write_ready_timeout", 32'(rdy), 32'h1);
         if (i > 0 && addr == 32'h0) begin
            exp_q.push_back(wq[i-1]);
            last_push_cyc = cyc;
         end
      end
      wq.delete();
   endtask

   task automatic ahb_read(input logic [31:0] addr, output logic [31:0] obs, output logic [31:0] exp);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
      @(posedge clk);
      #1;
      HSEL = 1'b0; HTRANS = 2'b00;
      @(negedge clk);
      obs = HRDATA;
      check("read_hresp", 32'(HRESP), 32'h0);
      #1;
      exp = addr[2] ? model_status() : 32'h0;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int w = 0; w < 4000 && got_q.size() < exp_q.size(); w++) step(1);
      step(4);
   endtask

   task automatic check_stream(input string tag);
      check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check({tag, "_char"}, 32'(got_q[i]), 32'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
      pulse_cyc.delete();
   endtask

   initial begin
      logic [31:0] obs;
      logic [31:0] exp;
      int bad;
      int sent;
      int n;

      resetn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
      HSIZE = 3'b010; HWDATA = '0; scroll = 1'b0; wrap_busy = 1'b0;
      stall_cycles = 0; release_cyc = -1; last_push_cyc = -1; fall_cyc = -1;
      #2;
      check("rst_font_we", 32'(font_we), 32'h0);
      check("rst_font_data", 32'(font_data), 32'h0);
      check("rst_hreadyout", 32'(HREADYOUT), 32'h1);
      check("rst_hrdata", HRDATA, 32'h0);
      check("rst_hresp", 32'(HRESP), 32'h0);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      step(1);
      ahb_read(32'h4, obs, exp);
      check("status_after_reset", obs, 32'h2);

      // Single character
      wq.push_back(8'h41);
      stall_cycles = 0;
      ahb_write_seq(32'h0);
      check("single_no_wait", 32'(stall_cycles), 32'h0);
      drain();
      check("single_one_pulse", 32'(pulse_cyc.size()), 32'h1);
      if (pulse_cyc.size() > 0) check("single_latency", 32'(pulse_cyc[0]), 32'(last_push_cyc + 1));
      check_stream("single");
      ahb_read(32'h4, obs, exp);
      check("single_status", obs, 32'h2);

      // DATA reads return zero; STATUS writes do nothing
      ahb_read(32'h0, obs, exp);
      check("data_read_zero", obs, exp);
      wq.push_back(8'hAB);
      stall_cycles = 0;
      ahb_write_seq(32'h4);
      check("stat_write_no_wait", 32'(stall_cycles), 32'h0);
      step(4);
      check("stat_write_no_push", 32'(got_q.size()), 32'h0);
      ahb_read(32'h4, obs, exp);
      check("stat_write_status", obs, 32'h2);

      // Back-to-back burst
      for (int i = 0; i < 16; i++) wq.push_back(8'(8'h30 + i));
      stall_cycles = 0;
      ahb_write_seq(32'h0);
      check("burst_no_wait", 32'(stall_cycles), 32'h0);
      drain();
      bad = 0;
      for (int i = 1; i < pulse_cyc.size(); i++) if (pulse_cyc[i] - pulse_cyc[i-1] != 2) bad++;
      check("burst_spacing", 32'(bad), 32'h0);
      check_stream("burst");

      // Fill to 16 under scroll, 17th stalls until the first pop
      scroll = 1'b1;
      for (int i = 0; i < 16; i++) wq.push_back(8'(8'h60 + i));
      stall_cycles = 0;
      ahb_write_seq(32'h0);
      check("fill_no_wait", 32'(stall_cycles), 32'h0);
      ahb_read(32'h4, obs, exp);
      check("full_status_model", obs, exp);
      check("full_status_const", obs, 32'h85);
      wq.push_back(8'h70);
      stall_cycles = 0;
      release_cyc = -1;
      fork
         ahb_write_seq(32'h0);
         begin
            step(6);
            scroll = 1'b0;
         end
      join
      check("full_stalled", 32'(stall_cycles > 0), 32'h1);
      if (pulse_cyc.size() > 0) check("stall_release_cycle", 32'(release_cyc), 32'(pulse_cyc[0]));
      drain();
      check_stream("full");

      // Newline raises scroll; next char waits for it to fall
      wq.push_back(8'h0A);
      wq.push_back(8'h42);
      fork
         ahb_write_seq(32'h0);
         begin
            for (int w = 0; w < 100; w++) begin
               @(negedge clk);
               if (font_we) break;
            end
            @(posedge clk);
            #1 scroll = 1'b1;
            repeat (960) @(posedge clk);
            #1 scroll = 1'b0;
            fall_cyc = cyc;
         end
      join
      drain();
      check("interlock_pulses", 32'(pulse_cyc.size()), 32'h2);
      if (pulse_cyc.size() > 1) check("interlock_resume", 32'(pulse_cyc[1]), 32'(fall_cyc + 1));
      check_stream("interlock");

      // Pointer wrap with random scroll gaps
      sent = 0;
      wrap_busy = 1'b1;
      fork
         begin
            while (sent < 40) begin
               n = $urandom_range(1, 6);
               if (n > 40 - sent) n = 40 - sent;
               for (int k = 0; k < n; k++) wq.push_back(8'($urandom_range(0, 255)));
               sent += n;
               ahb_write_seq(32'h0);
               ahb_read(32'h4, obs, exp);
               check("wrap_status", obs, exp);
               check("wrap_count_le16", 32'(obs[7:3] <= 5'd16), 32'h1);
            end
            wrap_busy = 1'b0;
         end
         begin
            while (wrap_busy) begin
               @(posedge clk);
               #1;
               if ($urandom_range(0, 3) == 0) scroll = ~scroll;
            end
         end
      join
      scroll = 1'b0;
      drain();
      check_stream("wrap");

      // Reset while characters are still queued and one is on the bus
      for (int i = 0; i < 6; i++) wq.push_back(8'(8'h50 + i));
      ahb_write_seq(32'h0);
      for (int w = 0; w < 50; w++) begin
         @(negedge clk);
         if (font_we) break;
      end
      #1 resetn = 1'b0;
      #1;
      check("midrst_font_we", 32'(font_we), 32'h0);
      check("midrst_font_data", 32'(font_data), 32'h0);
      check("midrst_hreadyout", 32'(HREADYOUT), 32'h1);
      check("midrst_hrdata", HRDATA, 32'h0);
      got_q.delete();
      exp_q.delete();
      pulse_cyc.delete();
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      step(6);
      check("midrst_discarded", 32'(got_q.size()), 32'h0);
      ahb_read(32'h4, obs, exp);
      check("midrst_status", obs, 32'h2);

      check("no_issue_while_scroll", 32'(scroll_err), 32'h0);
      check("no_back_to_back", 32'(b2b_err), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/console_char_bridge.md
# console_char_bridge

AHB-Lite slave that sits directly upstream of the VGA text console in the SoC. It accepts character writes from the Cortex-M0 and buffers them in a small FIFO. It then issues them to the console one at a time on `font_we`/`font_data`, never while the console is scrolling. This decouples CPU write bursts from the console's multi-cycle scroll refresh, and gives software a status register to poll.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: character slots; must be a power of two, 4–64.
- `PTR_W`, 4: log2(`FIFO_DEPTH`).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `resetn`  in  1  asynchronous, active-low reset.
- `HSEL`  in  1  slave select.
- `HADDR`  in  32  address; only `HADDR[2]` is decoded.
- `HTRANS`  in  2  transfer type; `HTRANS[1]`=1 means NONSEQ/SEQ.
- `HWRITE`  in  1  write strobe.
- `HSIZE`  in  3  ignored; all accesses are treated as word accesses.
- `HREADY`  in  1  bus-wide ready.
- `HWDATA`  in  32  write data; `[7:0]` is the character.
- `HREADYOUT`  out  1  slave ready; driven low to stall.
- `HRDATA`  out  32  read data.
- `HRESP`  out  1  always 0 (OKAY).
- `scroll`  in  1  console busy-scrolling flag, from the console.
- `font_we`  out  1  one-cycle character write strobe to the console.
- `font_data`  out  8  character code to the console.

## Operation
- **Address phase.** A transfer is valid when `HSEL & HREADY & HTRANS[1]`. Register `wr_q`, `rd_q` and `sel_data_q`=~`HADDR[2]` on that edge.
- **DATA register (offset 0x0).**
  - Write: pushes `HWDATA[7:0]` into the FIFO at the end of the data phase.
  - Read: returns 0.
- **STATUS register (offset 0x4), read-only.**
  - `[0]` full.
  - `[1]` empty.
  - `[2]` `scroll`.
  - `[PTR_W+3:3]` fill count.
  - All other bits are 0.
  - Writes to STATUS are ignored and complete with zero wait states.
- **Full stall.** If a DATA-write data phase finds the FIFO full, hold `HREADYOUT`=0. The push completes in the first cycle in which the FIFO is not full. `HWDATA` is sampled in the cycle `HREADYOUT` returns to 1.
- **Drain FSM.** Two states, IDLE and ISSUE.
  - IDLE → ISSUE when the FIFO is non-empty and `scroll`=0. On that edge: pop the head, set `font_data`<=head, set `font_we`<=1.
  - ISSUE → IDLE unconditionally on the next edge, with `font_we`<=0.
  - Result: at most one character every 2 cycles. This guarantees the console's registered `scroll`, raised by a newline on the last row, is visible before the next issue decision.
- **Simultaneous events.**
  - A push and a pop in the same cycle leave the count unchanged. This is allowed whenever the FIFO is not full at the start of the cycle.
  - A push never occurs into a full FIFO.
- **Wrap-around.** Read and write pointers are `PTR_W` bits and wrap modulo `FIFO_DEPTH`. The count is `PTR_W+1` bits.
- **Character content.** The bridge does not interpret characters. CR, LF and backspace pass through unchanged.

## Timing
- **Reset values** (asynchronous on `resetn`=0):
  - `HREADYOUT`=1, `HRDATA`=0, `HRESP`=0.
  - `font_we`=0, `font_data`=0.
  - FIFO empty, pointers 0, FSM in IDLE.
- **Reset mid-operation:** discards FIFO contents and any stalled transfer. `font_we` drops immediately.
- **Read data:** STATUS reads are combinational from current state during the data phase, with zero wait states.
- **Write-to-console latency:** a DATA write whose data phase ends at edge N with an empty FIFO and `scroll`=0 gives `font_we`=1 during cycle N+1→N+2.
- **Scroll hold-off:** `scroll`=1 holds the FSM in IDLE. Issue resumes on the first edge at which `scroll` is sampled 0.
- **Stall release:** `HREADYOUT` returns to 1 in the cycle after the pop edge that makes the FIFO non-full.

## Structure
- Shared package/header holds:
  - register offsets (`CON_DATA_OFS`=0x0, `CON_STAT_OFS`=0x4);
  - STATUS bit positions (`ST_FULL`=0, `ST_EMPTY`=1, `ST_SCROLL`=2, `ST_COUNT_LSB`=3);
  - the FSM state encoding (IDLE=0, ISSUE=1).
- One sub-module, `sync_fifo`:
  - parameterised by width (8) and depth;
  - provides push/pop/full/empty/count;
  - registered head output is available in the same cycle as not-empty.
- The AHB decode and the drain FSM stay in the top level.

## Test plan
- **Reset:** assert `resetn`=0 mid-stream → all outputs at reset values; STATUS reads 0x2 afterwards.
- **Single write:** write 0x41 to 0x0 → exactly one `font_we` pulse with `font_data`=0x41, one cycle after the data phase; STATUS returns to 0x2.
- **Burst of 16:** write 0x30..0x3F back-to-back → no wait states; `font_we` pulses every 2nd cycle in order 0x30..0x3F.
- **Full stall:** hold `scroll`=1 and write 17 characters → 17th data phase has `HREADYOUT`=0 and STATUS count=16. Drop `scroll` → first pop, stall released next cycle, all 17 characters delivered in order.
- **Scroll interlock:** write 0x0A followed by 0x42, and raise `scroll` for 960 cycles on the edge after the 0x0A `font_we` → 0x42 is issued only after `scroll` falls, never while it is high.
- **Pointer wrap:** push/pop 40 characters with random `scroll` gaps → output sequence matches input; count never exceeds 16.
